// File: rtl/tinker_fetch_queue.sv
// tinker_fetch_queue: PC owner and instruction fetch queue for the Tinker core.
// Issues one 4-byte fetch at a time over a valid/ready memory port, buffers
// each returned instruction with its PC in a DEPTH-entry FIFO toward decode,
// and flushes everything (dropping any in-flight response) on a redirect.
// Optional per-event counters are enabled with `define TINKER_FETCH_STATS_EN.

module tinker_fetch_queue #(
    parameter int unsigned        ADDR_W   = 64,
    parameter int unsigned        INSTR_W  = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(64'h2000)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_req_valid,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_req_ready,
    input  logic               mem_rsp_valid,
    input  logic [INSTR_W-1:0] mem_rsp_instr,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_dropped
);

    localparam int unsigned        PTR_W    = $clog2(DEPTH);
    localparam int unsigned        CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    // IDLE: free to issue; WAIT: one request outstanding, response kept;
    // DROP: one request outstanding, response will be discarded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

    logic               accept;
    logic               push_en;
    logic               pop_en;

    // Handshake qualifiers and head-of-queue outputs.
    always_comb begin
        mem_req_valid = !reset && (state_q == IDLE) && (count_q < FULL_CNT) && !redirect;
        mem_req_addr  = pc_q;
        accept        = mem_req_valid && mem_req_ready;
        push_en       = (state_q == WAIT) && mem_rsp_valid && !redirect;
        instr_valid   = (count_q != '0) && !redirect;
        pop_en        = instr_valid && instr_ready;
        instr         = instr_valid ? instr_mem_q[rd_ptr_q] : '0;
        instr_pc      = instr_valid ? pc_mem_q[rd_ptr_q]    : '0;
    end

    // Next-state logic for the request FSM, PC and FIFO bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        unique case (state_q)
            IDLE: if (accept) state_d = WAIT;
            WAIT: begin
                if (mem_rsp_valid) state_d = IDLE;
                else if (redirect) state_d = DROP;
            end
            DROP: if (mem_rsp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            pc_d     = {redirect_pc[ADDR_W-1:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (accept) pc_d = pc_q + ADDR_W'(4);
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // FIFO storage write; the PC of a response is the address that was issued.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count==0 already marks every entry invalid.
        if (push_en) begin
            instr_mem_q[wr_ptr_q] <= mem_rsp_instr;
            pc_mem_q[wr_ptr_q]    <= pc_q - ADDR_W'(4);
        end
    end

`ifdef TINKER_FETCH_STATS_EN
    logic [31:0] fetched_q;
    logic [31:0] dropped_q;
    logic        drop_en;

    // A response is discarded when it lands in DROP or together with a redirect.
    assign drop_en = mem_rsp_valid &&
                     ((state_q == DROP) || ((state_q == WAIT) && redirect));

    // Wrapping event counters for pushed and discarded responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            if (push_en) fetched_q <= fetched_q + 32'd1;
            if (drop_en) dropped_q <= dropped_q + 32'd1;
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_dropped = dropped_q;
`else
    assign stat_fetched = '0;
    assign stat_dropped = '0;
`endif

endmodule

// File: doc/tinker_fetch_queue.md
Name: tinker_fetch_queue

Overview:
Parametrised successor to the Tinker fetch stage. It owns the PC and issues 4-byte instruction requests over a valid/ready memory port that can take several cycles to respond. Returned instructions are buffered, each tagged with its PC, in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake. A branch redirect flushes the queue and discards any in-flight response.

Parameters:
ADDR_W, 64, PC and memory address width
INSTR_W, 32, instruction width
DEPTH, 4, FIFO entries; power of 2, at least 2
RESET_PC, 64'h2000, PC loaded on reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
redirect  in  1  branch taken; highest priority
redirect_pc  in  ADDR_W  branch target; bits [1:0] ignored (treated as 0)
mem_req_valid  out  1  instruction fetch request
mem_req_addr  out  ADDR_W  fetch address, always equal to fetch_pc
mem_req_ready  in  1  memory accepts the request
mem_rsp_valid  in  1  instruction returned
mem_rsp_instr  in  INSTR_W  returned instruction
instr_valid  out  1  FIFO head is valid
instr  out  INSTR_W  head instruction; 0 when instr_valid=0
instr_pc  out  ADDR_W  PC of the head instruction; 0 when instr_valid=0
instr_ready  in  1  decode consumes the head
stat_fetched  out  32  see Optional Feature
stat_dropped  out  32  see Optional Feature

Behaviour:
- Reset values:
  - fetch_pc=RESET_PC; count, rd_ptr, wr_ptr = 0; state=IDLE.
  - mem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, stats=0.
- A reset mid-operation abandons any outstanding request. A response arriving after reset is ignored.
- FSM states: IDLE, WAIT, DROP. At most one request is outstanding.
- mem_req_valid = (state==IDLE) && (count<DEPTH) && !redirect. This is combinational.
- IDLE:
  - On valid&&ready, the request is accepted: fetch_pc += 4 (wraps mod 2^ADDR_W), state goes to WAIT.
  - mem_req_addr is held stable while valid && !ready. The only exception is a redirect, which withdraws the request.
- WAIT:
  - On mem_rsp_valid, {fetch_pc-4, mem_rsp_instr} is pushed at wr_ptr and state goes to IDLE.
  - The earliest response is the cycle after accept.
  - A slot is always free, because issue required count<DEPTH and count cannot grow while waiting.
- DROP:
  - On mem_rsp_valid, the response is discarded and state goes to IDLE.
- mem_rsp_valid is ignored in IDLE.
- Output side:
  - instr_valid = (count!=0) && !redirect.
  - A pop occurs on instr_valid && instr_ready; rd_ptr advances.
  - A push and a pop in the same cycle leave count unchanged.
  - Pointers wrap mod DEPTH; count width is clog2(DEPTH)+1.
- Latency:
  - A response pushed in cycle N is visible at the outputs in cycle N+1 (no bypass).
  - The first request is issued the cycle after reset deasserts.
- Redirect (cycle R), which overrides everything else:
  - FIFO flushed: count, rd_ptr, wr_ptr = 0 at R+1. No pop occurs in R.
  - fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - State transitions: WAIT goes to DROP; WAIT with mem_rsp_valid in the same cycle R goes to IDLE, response discarded; DROP stays DROP; IDLE stays IDLE.
  - The new request is issued at R+1 at the earliest.
- Back-to-back redirects: the last one wins, and only a single response is dropped.
- Full: with count==DEPTH there is no request. Requests resume in the cycle after the pop that frees a slot.

Optional Feature:
TINKER_FETCH_STATS_EN
- Defined:
  - stat_fetched increments on every push.
  - stat_dropped increments on every discarded response: a DROP-state response, or a response arriving in the same cycle as a redirect.
  - Both are 32-bit, wrap at 2^32, and are cleared by reset.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
1. Reset release, mem_req_ready=1, response 1 cycle after each accept, instr_ready=1 -> requests at 0x2000, 0x2004, 0x2008; instr_pc sequence 0x2000, 0x2004, 0x2008, one instruction every 2 cycles.
2. instr_ready=0, fast memory -> after 4 pushes count=4 and mem_req_valid stays 0. Set instr_ready=1 for 1 cycle -> pop 0x2000, and the next cycle requests 0x2010.
3. Redirect to 0x3001 while in WAIT; memory responds 3 cycles later with 0xDEADBEEF -> response discarded, FIFO empty. Next request is at 0x3000 and the first instr_pc is 0x3000. With STATS_EN, stat_dropped=1.
4. Redirect in the same cycle as mem_rsp_valid -> nothing pushed, state IDLE, request to the target at R+1, instr_valid=0 during R.
5. mem_req_ready=0 for 5 cycles -> mem_req_valid=1 with mem_req_addr constant 0x2000 throughout, fetch_pc unchanged.
6. Reset asserted in WAIT with a response arriving the next cycle -> response ignored, count=0, first post-reset request at 0x2000.
